// File: rtl/alu_pkg.sv
// Shared opcode encoding and shift-direction helper for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SBB = 3'b110,
        OP_SHF = 3'b111
    } op_t;

    // Operand-B bit selecting shift direction (the MSB of the operand).
    function automatic int shift_dir_bit(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, carry/borrow/shift-out and status flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam int DIR = shift_dir_bit(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic               use_cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] shl_ext;
    logic [2*WIDTH-1:0] shr_ext;

    always_comb begin
        use_cin = (op == OP_ADC) || (op == OP_SBB);
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin & use_cin};
        diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin & use_cin};
        amt     = b[SHW-1:0];
        // Widened shifts land the last bit shifted out just beyond the result field.
        shl_ext = {{WIDTH{1'b0}}, a} << amt;
        shr_ext = {a, {WIDTH{1'b0}}} >> amt;

        y    = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                y    = diff[WIDTH-1:0];
                cout = diff[WIDTH];
                ovf  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHF: begin
                if (b[DIR]) begin
                    y    = shr_ext[2*WIDTH-1:WIDTH];
                    cout = shr_ext[WIDTH-1];
                end else begin
                    y    = shl_ext[WIDTH-1:0];
                    cout = shl_ext[WIDTH];
                end
            end
            default: y = '0;
        endcase

        zero = (y == '0);
        neg  = y[MSB];
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a chained carry flag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             carry_flag
);

    op_t              op_e;
    logic             accept;
    logic             is_arith;
    logic             cin;
    logic [WIDTH-1:0] core_y;
    logic             core_cout;
    logic             core_zero;
    logic             core_neg;
    logic             core_ovf;

    always_comb begin
        op_e     = op_t'(op);
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        is_arith = (op_e == OP_ADD) || (op_e == OP_SUB) ||
                   (op_e == OP_ADC) || (op_e == OP_SBB);
        cin      = flag_clr ? 1'b0 : carry_flag;
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .b    (b),
        .op   (op_e),
        .cin  (cin),
        .y    (core_y),
        .cout (core_cout),
        .zero (core_zero),
        .neg  (core_neg),
        .ovf  (core_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            y          <= '0;
            cout       <= 1'b0;
            zero       <= 1'b0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                y         <= core_y;
                cout      <= core_cout;
                zero      <= core_zero;
                neg       <= core_neg;
                ovf       <= core_ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // An accepted arithmetic op outranks a concurrent flag_clr.
            if (accept && is_arith) begin
                carry_flag <= core_cout;
            end else if (flag_clr) begin
                carry_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): vector table, handshake sequences, random model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       flag_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       carry_flag;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .flag_clr   (flag_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .cout       (cout),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fc;
        logic [7:0] ey;
        logic       ec;
        logic       ev;
        logic       ecarry;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       v;
    } res_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference computed from integer arithmetic and signed range checks.
    function automatic res_t ref_alu(input logic [2:0] o, input int av, input int bv, input int c);
        res_t r;
        int   sa, sb, t, st, s;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        r.y = 8'h00; r.c = 1'b0; r.v = 1'b0;
        case (o)
            3'd0, 3'd5: begin
                if (o == 3'd0) c = 0;
                t   = av + bv + c;
                st  = sa + sb + c;
                r.y = 8'(t);
                r.c = (t > 255);
                r.v = (st > 127) || (st < -128);
            end
            3'd1, 3'd6: begin
                if (o == 3'd1) c = 0;
                t   = av - bv - c;
                st  = sa - sb - c;
                r.y = 8'(t);
                r.c = (t < 0);
                r.v = (st > 127) || (st < -128);
            end
            3'd2: r.y = 8'(av & bv);
            3'd3: r.y = 8'(av | bv);
            3'd4: r.y = 8'(av ^ bv);
            default: begin
                s = bv % 8;
                if (bv >= 128) begin
                    r.y = 8'(av >> s);
                    r.c = (s == 0) ? 1'b0 : 1'((av >> (s - 1)) % 2);
                end else begin
                    r.y = 8'((av << s) % 256);
                    r.c = (s == 0) ? 1'b0 : 1'((av >> (8 - s)) % 2);
                end
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       m_valid;
    logic       m_carry;
    res_t       m_res;
    res_t       r;
    logic       acc;
    logic       arith;
    string      tag;

    initial begin
        tbl[0]  = '{3'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'd2, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'd5, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{3'd5, 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{3'd6, 8'h05, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{3'd5, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3'd6, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{3'd4, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{3'd3, 8'h50, 8'h0A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{3'd7, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{3'd7, 8'h81, 8'h81, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{3'd7, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{3'd7, 8'h81, 8'h87, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{3'd7, 8'h03, 8'h07, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        flag_clr = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_y", y, 0);
        chk("rst_carry", carry_flag, 0);
        rst = 1'b0;
        tick();

        // Directed vector table, one op per cycle with out_ready held high.
        for (int i = 0; i < 19; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; flag_clr = tbl[i].fc;
            tick();
            tag = $sformatf("vec%0d", i);
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_y"}, y, tbl[i].ey);
            chk({tag, "_cout"}, cout, tbl[i].ec);
            chk({tag, "_ovf"}, ovf, tbl[i].ev);
            chk({tag, "_zero"}, zero, (tbl[i].ey == 8'h00));
            chk({tag, "_neg"}, neg, tbl[i].ey[7]);
            chk({tag, "_carry"}, carry_flag, tbl[i].ecarry);
        end

        // Drain, then backpressure with a pending op that must not be consumed.
        in_valid = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain_valid", out_valid, 0);
        in_valid = 1'b1; out_ready = 1'b0; op = 3'd0; a = 8'h01; b = 8'h02;
        #1;
        chk("bp_ready_empty", in_ready, 1);
        tick();
        chk("bp_first_y", y, 8'h03);
        chk("bp_first_carry", carry_flag, 0);
        a = 8'hFF; b = 8'h01;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready_low", in_ready, 0);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_y", y, 8'h03);
            chk("bp_hold_cout", cout, 0);
            chk("bp_hold_carry", carry_flag, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_y", y, 8'h00);
        chk("bp_second_zero", zero, 1);
        chk("bp_second_carry", carry_flag, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty_valid", out_valid, 0);

        // flag_clr with no transaction.
        flag_clr = 1'b1;
        tick();
        chk("clr_alone_carry", carry_flag, 0);
        flag_clr = 1'b0;

        // Asynchronous reset while a result is held and carry is set.
        in_valid = 1'b1; out_ready = 1'b0; op = 3'd0; a = 8'hFF; b = 8'h02;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_carry", carry_flag, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_y", y, 0);
        chk("arst_cout", cout, 0);
        chk("arst_neg", neg, 0);
        chk("arst_carry", carry_flag, 0);
        chk("arst_in_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        tick();

        // Random traffic against the model: 16 streaming ops, then random handshakes.
        m_valid = 1'b0; m_carry = 1'b0; m_res = '{8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 80; i++) begin
            in_valid  = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = (i < 16) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            flag_clr  = 1'($urandom_range(0, 5) == 0);
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            #1;
            chk("rnd_in_ready", in_ready, (!m_valid || out_ready));
            acc   = in_valid && (!m_valid || out_ready);
            arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd5) || (op == 3'd6);
            r = ref_alu(op, int'(a), int'(b), (flag_clr ? 0 : int'(m_carry)));
            if (acc) begin
                m_valid = 1'b1;
                m_res   = r;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc && arith) m_carry = r.c;
            else if (flag_clr) m_carry = 1'b0;
            tick();
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_carry", carry_flag, m_carry);
            if (m_valid) begin
                chk("rnd_y", y, m_res.y);
                chk("rnd_cout", cout, m_res.c);
                chk("rnd_ovf", ovf, m_res.v);
                chk("rnd_zero", zero, (m_res.y == 8'h00));
                chk("rnd_neg", neg, m_res.y[7]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Accepts one operation per cycle on a valid/ready input handshake and presents a registered result plus flags on a valid/ready output handshake.
- Holds an architectural carry flag so that ADC/SBB can chain multi-word arithmetic across successive transactions.
- Sits between the operand-issue logic and the result write-back stage.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Operation presented.
- in_ready  output  1  Block can accept the operation.
- a  input  WIDTH  Operand A.
- b  input  WIDTH  Operand B; b[SHW-1:0] is the shift amount for shift ops.
- op  input  3  Opcode, see Behaviour.
- flag_clr  input  1  Synchronous clear of the stored carry flag.
- out_valid  output  1  Result register holds an unconsumed result.
- out_ready  input  1  Downstream accepts the result.
- y  output  WIDTH  Result.
- cout  output  1  Carry/borrow/shift-out for this result.
- zero  output  1  Set when y == 0.
- neg  output  1  Equals y[WIDTH-1].
- ovf  output  1  Signed overflow; ADD/ADC/SUB/SBB only, 0 otherwise.
- carry_flag  output  1  Stored architectural carry.

Behaviour:
- Reset (asynchronous, rst=1): out_valid=0, y=0, cout=0, zero=0, neg=0, ovf=0, carry_flag=0. in_ready=1 while out_valid=0.
- Reset mid-operation discards the held result; nothing is replayed.
- in_ready = !out_valid || out_ready (combinational). No skid buffer.
- Accept condition: in_valid && in_ready. On accept, the result, flags and out_valid=1 are registered next edge. Latency is 1 cycle.
- Throughput is 1 op/cycle when out_ready is held high.
- Output side: out_valid && out_ready with no accept in the same cycle -> out_valid=0.
- Accept and output drain in the same cycle -> the new result replaces the old and out_valid stays 1.
- While out_valid && !out_ready, y and all flags are held stable.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 000 ADD: {cout,y} = a + b.
  - 001 SUB: y = a - b; cout = borrow (1 iff a < b unsigned).
  - 010 AND: y = a & b; cout = 0.
  - 011 OR: y = a | b; cout = 0.
  - 100 XOR: y = a ^ b; cout = 0.
  - 101 ADC: {cout,y} = a + b + cin.
  - 110 SBB: y = a - b - cin; cout = borrow.
  - 111 SHL/SHR: direction set by b[WIDTH-1] (0 = logical left, 1 = logical right). Amount s = b[SHW-1:0]. cout = last bit shifted out, 0 when s = 0.
- cin = carry_flag, forced to 0 when flag_clr is asserted in the same cycle.
- ovf for ADD/ADC: a and b have the same sign and the result sign differs.
- ovf for SUB/SBB: a and b have different signs and the result sign differs from a.
- carry_flag update priority, highest first:
  1. Accepted ADD/SUB/ADC/SBB -> carry_flag <= cout.
  2. Otherwise flag_clr -> 0.
  3. Otherwise hold.
- Logic ops and shifts do not modify carry_flag.
- Ops not accepted (in_ready=0) have no effect on any state, including carry_flag.
- No X propagation: every opcode assigns every output register. No latches.

Decomposition:
- alu_pkg: op_t enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC, OP_SBB, OP_SHF) and a SHIFT_DIR_BIT constant (WIDTH-1 resolved in the module).
- alu_core: one purely combinational sub-module, parameter WIDTH. Inputs a, b, op, cin; outputs y, cout, zero, neg, ovf.
- alu_pipe: holds the handshake, the result/flag registers and carry_flag.

Test Plan:
- Reset check: assert rst mid-stream with out_valid=1 -> all outputs 0, carry_flag=0, in_ready=1 immediately, with no clock edge needed.
- WIDTH=8 ADD: a=0xF0, b=0x20 -> next cycle y=0x10, cout=1, carry_flag=1, ovf=0. Then ADC a=0x00, b=0x00 -> y=0x01, cout=0, carry_flag=0.
- SUB a=0x05, b=0x07 -> y=0xFE, cout=1, neg=1. SUB a=0x80, b=0x01 -> y=0x7F, ovf=1. AND 0x0F/0xF0 -> y=0, zero=1, cout=0, carry_flag unchanged.
- Backpressure: hold out_ready=0 for 3 cycles after one accepted op -> in_ready=0, y stable, a second in_valid is not consumed. Raise out_ready -> same-cycle accept of the second op, out_valid stays 1.
- Simultaneous flag_clr with ADC: carry_flag=1, a=0x01, b=0x01 -> y=0x02 (cin forced 0), carry_flag=0. flag_clr alone with no accept -> carry_flag=0.
- Shift: a=0x81, b=0x01 -> y=0x02, cout=1. a=0x81, b=0x81 (right by 1) -> y=0x40, cout=1. Amount 0 -> y=a, cout=0.
- Streaming: 16 back-to-back random ops with out_ready=1 -> one result per cycle, in order, matching the reference model.
